// File: rtl/snake_head_stepper_if.sv
// Joystick-to-head bundle between buttons and body/renderer logic.
// Ports: direction/start/pause in; head_x/head_y/heading/step/running/game_over out.
interface snake_head_stepper_if #(
  parameter int X_W = 6,
  parameter int Y_W = 5
);
  logic [1:0]     direction;
  logic           start;
  logic           pause;
  logic [X_W-1:0] head_x;
  logic [Y_W-1:0] head_y;
  logic [1:0]     heading;
  logic           step;
  logic           running;
  logic           game_over;

  modport master (
    output direction, start, pause,
    input  head_x, head_y, heading,
    input  step, running, game_over
  );

  modport slave (
    input  direction, start, pause,
    output head_x, head_y, heading,
    output step, running, game_over
  );
endinterface

// File: rtl/snake_head_stepper.sv
// Snake head stepper: ticks the game, rejects reversals, moves head, detects walls.
// Ports: clk, rst_n (async low), bus (slave: direction/start/pause -> head/step/flags).
module snake_head_stepper #(
  parameter int GRID_W   = 40,
  parameter int GRID_H   = 30,
  parameter int X_W      = 6,
  parameter int Y_W      = 5,
  parameter int TICK_DIV = 12500000,
  parameter int START_X  = 20,
  parameter int START_Y  = 15
) (
  input logic clk,
  input logic rst_n,
  snake_head_stepper_if.slave bus
);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
  localparam logic [1:0] UP    = 2'b00;
  localparam logic [1:0] RIGHT = 2'b01;
  localparam logic [1:0] DOWN  = 2'b10;
  localparam logic [1:0] LEFT  = 2'b11;
  localparam logic [X_W-1:0] SX = X_W'(START_X);
  localparam logic [Y_W-1:0] SY = Y_W'(START_Y);
  localparam logic [X_W-1:0] XMAX = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0] YMAX = Y_W'(GRID_H - 1);

  typedef enum logic [1:0] {
    IDLE, RUN, DEAD
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [X_W-1:0] x_q, x_d, nx;
  logic [Y_W-1:0] y_q, y_d, ny;
  logic [1:0]     hd_q, hd_d, new_hd;
  logic           step_q, step_d;
  logic           hit;

  // Opposite directions differ only in bit 1.
  assign new_hd = (bus.direction == (hd_q ^ 2'b10))
                ? hd_q : bus.direction;

  // Wall check happens before the move, so no wrap can leak out.
  always_comb begin
    hit = 1'b0;
    nx  = x_q;
    ny  = y_q;
    unique case (new_hd)
      UP: begin
        if (y_q == '0) hit = 1'b1;
        else ny = y_q - Y_W'(1);
      end
      DOWN: begin
        if (y_q == YMAX) hit = 1'b1;
        else ny = y_q + Y_W'(1);
      end
      LEFT: begin
        if (x_q == '0) hit = 1'b1;
        else nx = x_q - X_W'(1);
      end
      RIGHT: begin
        if (x_q == XMAX) hit = 1'b1;
        else nx = x_q + X_W'(1);
      end
      default: hit = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    hd_d    = hd_q;
    step_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (!bus.pause) begin
          if (cnt_q == LAST) begin
            cnt_d = '0;
            hd_d  = new_hd;
            if (hit) begin
              state_d = DEAD;
            end else begin
              x_d    = nx;
              y_d    = ny;
              step_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DEAD: begin
        if (bus.start) begin
          state_d = RUN;
          cnt_d   = '0;
          x_d     = SX;
          y_d     = SY;
          hd_d    = UP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= SX;
      y_q     <= SY;
      hd_q    <= UP;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      hd_q    <= hd_d;
      step_q  <= step_d;
    end
  end

  assign bus.head_x    = x_q;
  assign bus.head_y    = y_q;
  assign bus.heading   = hd_q;
  assign bus.step      = step_q;
  assign bus.running   = (state_q == RUN);
  assign bus.game_over = (state_q == DEAD);
endmodule

// File: tb/tb_snake_head_stepper.sv
// Bench for snake_head_stepper: cycle model plus directed game scenarios.
// Small grid 8x6, tick every 4 cycles, start at (4,3).
module tb_snake_head_stepper;
  localparam int GW = 8;
  localparam int GH = 6;
  localparam int TD = 4;
  localparam int SX = 4;
  localparam int SY = 3;
  localparam int D_UP = 0, D_RT = 1, D_DN = 2, D_LT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;

  snake_head_stepper_if #(.X_W(3), .Y_W(3)) bus ();

  snake_head_stepper #(
    .GRID_W(GW), .GRID_H(GH), .X_W(3), .Y_W(3),
    .TICK_DIV(TD), .START_X(SX), .START_Y(SY)
  ) u_dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Behavioural model: game phase, integer coordinates, countdown to next move.
  int m_phase = 0;
  int m_x = SX;
  int m_y = SY;
  int m_hd = D_UP;
  int m_left = TD;
  bit m_step = 0;

  function automatic int ddx(int d);
    return (d == D_RT) ? 1 : (d == D_LT) ? -1 : 0;
  endfunction
  function automatic int ddy(int d);
    return (d == D_DN) ? 1 : (d == D_UP) ? -1 : 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_x = SX; m_y = SY;
      m_hd = D_UP; m_left = TD; m_step = 0;
    end else begin
      m_step = 0;
      if (m_phase == 0) begin
        if (bus.start) begin m_phase = 1; m_left = TD; end
      end else if (m_phase == 2) begin
        if (bus.start) begin
          m_phase = 1; m_left = TD;
          m_x = SX; m_y = SY; m_hd = D_UP;
        end
      end else if (!bus.pause) begin
        if (m_left > 1) begin
          m_left--;
        end else begin
          int d, tx, ty;
          m_left = TD;
          d = int'(bus.direction);
          if (ddx(d) == -ddx(m_hd) && ddy(d) == -ddy(m_hd)) d = m_hd;
          m_hd = d;
          tx = m_x + ddx(d);
          ty = m_y + ddy(d);
          if (tx < 0 || tx >= GW || ty < 0 || ty >= GH) m_phase = 2;
          else begin m_x = tx; m_y = ty; m_step = 1; end
        end
      end
    end
  end

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("m_x", int'(bus.head_x), m_x);
    chk("m_y", int'(bus.head_y), m_y);
    chk("m_heading", int'(bus.heading), m_hd);
    chk("m_step", int'(bus.step), int'(m_step));
    chk("m_running", int'(bus.running), int'(m_phase == 1));
    chk("m_game_over", int'(bus.game_over), int'(m_phase == 2));
  end

  task automatic wait_step(string nm, int exp_c, int ex, int ey, int eh);
    int got = 0;
    for (int i = 1; i <= exp_c + 4 && got == 0; i++) begin
      @(negedge clk); #1;
      if (bus.step) got = i;
    end
    chk({nm, "_lat"}, got, exp_c);
    chk({nm, "_x"}, int'(bus.head_x), ex);
    chk({nm, "_y"}, int'(bus.head_y), ey);
    chk({nm, "_hd"}, int'(bus.heading), eh);
  endtask

  task automatic chk_all(string nm, int ex, int ey, int eh,
                         int es, int er, int eg);
    chk({nm, "_x"}, int'(bus.head_x), ex);
    chk({nm, "_y"}, int'(bus.head_y), ey);
    chk({nm, "_hd"}, int'(bus.heading), eh);
    chk({nm, "_step"}, int'(bus.step), es);
    chk({nm, "_run"}, int'(bus.running), er);
    chk({nm, "_over"}, int'(bus.game_over), eg);
  endtask

  task automatic pulse_start();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    #1;
  endtask

  initial begin
    int seen;
    bus.direction = 2'(D_UP);
    bus.start = 1'b0;
    bus.pause = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk_all("reset", SX, SY, D_UP, 0, 0, 0);
    rst_n = 1'b1;

    // Straight up into the top wall.
    pulse_start();
    chk_all("started", SX, SY, D_UP, 0, 1, 0);
    wait_step("up1", 4, 4, 2, D_UP);
    wait_step("up2", 4, 4, 1, D_UP);
    wait_step("up3", 4, 4, 0, D_UP);
    repeat (4) @(negedge clk);
    #1 chk_all("top_wall", 4, 0, D_UP, 0, 0, 1);

    // Restart, reversal rejected, then a legal turn to the right wall.
    pulse_start();
    chk_all("restart1", SX, SY, D_UP, 0, 1, 0);
    bus.direction = 2'(D_DN);
    wait_step("reverse", 4, 4, 2, D_UP);
    bus.direction = 2'(D_RT);
    wait_step("turn_r", 4, 5, 2, D_RT);
    wait_step("right2", 4, 6, 2, D_RT);
    wait_step("right3", 4, 7, 2, D_RT);
    repeat (4) @(negedge clk);
    #1 chk_all("right_wall", 7, 2, D_RT, 0, 0, 1);

    bus.direction = 2'(D_UP);
    pulse_start();
    chk_all("restart2", SX, SY, D_UP, 0, 1, 0);
    wait_step("after_rs", 4, 4, 2, D_UP);

    // Pause held across the pending tick.
    repeat (3) @(negedge clk);
    bus.pause = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk); #1;
      if (bus.step) seen++;
    end
    chk("pause_nostep", seen, 0);
    bus.pause = 1'b0;
    wait_step("unpause", 1, 4, 1, D_UP);
    wait_step("resume", 4, 4, 0, D_UP);

    // Direction wiggle between ticks: only the last value counts.
    bus.direction = 2'(D_LT);
    @(negedge clk); bus.direction = 2'(D_UP);
    @(negedge clk); bus.direction = 2'(D_LT);
    wait_step("toggle", 2, 3, 0, D_LT);
    wait_step("left2", 4, 2, 0, D_LT);

    // Async reset right on top of a step pulse.
    rst_n = 1'b0;
    #1 chk_all("async_rst", SX, SY, D_UP, 0, 0, 0);
    @(negedge clk); #1 rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk); #1;
      if (bus.step) seen++;
    end
    chk("idle_nostep", seen, 0);
    chk_all("idle_hold", SX, SY, D_UP, 0, 0, 0);
    pulse_start();
    wait_step("post_rst", 4, 3, 3, D_LT);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
